// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline definitions: bubble encoding, base opcodes and the
// decode-to-exe issue state encoding.
package rv32_pipe_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } de_state_t;

endpackage

// File: rtl/de_issue_operand_fwd_mux.sv
// Per-operand select between the register-file value and the forwarded value.
module operand_fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic            hazard,
  input  logic [XLEN-1:0] fwd,
  input  logic [XLEN-1:0] rf,
  output logic [XLEN-1:0] y
);

  assign y = hazard ? fwd : rf;

endmodule

// File: rtl/de_issue.sv
// Decode-to-exe issue register with load-use stall and flush bubbles.
// Optional bubble counter enabled by defining DE_ISSUE_BUBBLE_CNT_EN.
module de_issue
  import rv32_pipe_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_de,
  input  logic [XLEN-1:0]  pc_de,
  input  logic             valid_de,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             stall,
  input  logic             hazard_a,
  input  logic             hazard_b,
  input  logic [XLEN-1:0]  data_a_mgr,
  input  logic [XLEN-1:0]  data_b_mgr,
  input  logic             flush,
  output logic             hold_de,
  output logic [31:0]      instr_exe,
  output logic [XLEN-1:0]  pc_exe,
  output logic             valid_exe,
  output logic [XLEN-1:0]  op_a_exe,
  output logic [XLEN-1:0]  op_b_exe,
  output logic [CNT_W-1:0] bubble_cnt,
  output de_state_t        state
);

  de_state_t       state_next;
  logic            bubble;
  logic            hold_c;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .hazard(hazard_a), .fwd(data_a_mgr), .rf(rs1_data), .y(op_a)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .hazard(hazard_b), .fwd(data_b_mgr), .rf(rs2_data), .y(op_b)
  );

  // Priority inside each state is flush, then stall, then issue.
  always_comb begin
    bubble     = 1'b0;
    hold_c     = 1'b0;
    state_next = state;
    case (state)
      S_RUN: begin
        if (flush) begin
          bubble     = 1'b1;
          state_next = S_FLUSH;
        end else if (stall && valid_de) begin
          bubble     = 1'b1;
          hold_c     = 1'b1;
          state_next = S_STALL;
        end
      end
      S_STALL: begin
        if (flush) begin
          bubble     = 1'b1;
          state_next = S_FLUSH;
        end else if (stall) begin
          bubble = 1'b1;
          hold_c = 1'b1;
        end else begin
          state_next = S_RUN;
        end
      end
      S_FLUSH: begin
        bubble     = 1'b1;
        state_next = S_RUN;
      end
      default: begin
        bubble     = 1'b1;
        state_next = S_RUN;
      end
    endcase
  end

  assign hold_de = hold_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
    if (rst || bubble) begin
      instr_exe <= NOP_INSTR;
      pc_exe    <= '0;
      valid_exe <= 1'b0;
      op_a_exe  <= '0;
      op_b_exe  <= '0;
    end else begin
      instr_exe <= instr_de;
      pc_exe    <= pc_de;
      valid_exe <= valid_de;
      op_a_exe  <= op_a;
      op_b_exe  <= op_b;
    end
  end

`ifdef DE_ISSUE_BUBBLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Only bubbles that displace real or pending work are counted; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bubble && (valid_de || state != S_RUN) && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule
